// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky error flags and optional FWFT read.
// Latency: write-to-visible 1 cycle; FWFT=0 read data 1 cycle after rd, FWFT=1 head word shown combinationally.
// Backpressure: writes when full are dropped (overflow), reads when empty are dropped (underflow); en=0 freezes all state.
module sync_fifo_ctrl #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic udf_set;

  // Status flags are all derived from the registered count so they move together.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Accept logic: a write into a full FIFO is fine if a read frees a slot on the same edge.
  always_comb begin
    rd_acc  = en & rd & ~empty;
    wr_acc  = en & wr & (~full | rd_acc);
    ovf_set = en & wr & full & ~rd_acc;
    udf_set = en & rd & empty;
  end

  // Next-state for pointers, occupancy and sticky error flags; a new error beats a clear.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + CNT_ONE;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
    if (en && clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
    if (udf_set) begin
      underflow_d = 1'b1;
    end
  end

  // Control state registers; everything holds while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (en) begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; rd acts as the pop acknowledge.
      always_comb begin
        dout       = mem[rd_ptr_q];
        dout_valid = ~empty;
      end
    end else begin : g_std
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              dout_valid_q, dout_valid_d;

      // Registered read port: capture the head word on an accepted read, pulse valid for one cycle.
      always_comb begin
        dout_d       = dout_q;
        dout_valid_d = rd_acc;
        if (rd_acc) begin
          dout_d = mem[rd_ptr_q];
        end
      end

      // Read data registers, frozen together with the rest of the state when en is low.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else if (en) begin
          dout_q       <= dout_d;
          dout_valid_q <= dout_valid_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dout_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl: a default FWFT=0 instance and a FWFT=1 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Covers fill/drain, concurrent access at both limits, enable/clear and async reset.
module tb_sync_fifo_ctrl;

  logic        clk;
  logic        rst;

  logic        en, wr, rd, clr_err;
  logic [31:0] din;
  logic [31:0] dout;
  logic        dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0]  count;

  logic        f_en, f_wr, f_rd, f_clr_err;
  logic [31:0] f_din;
  logic [31:0] f_dout;
  logic        f_dout_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [3:0]  f_count;

  int checks;
  int errors;

  sync_fifo_ctrl #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .rd(rd), .din(din), .clr_err(clr_err),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_ctrl #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .en(f_en), .wr(f_wr), .rd(f_rd), .din(f_din), .clr_err(f_clr_err),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic w, input logic r, input logic c, input logic [31:0] d);
    en = e; wr = w; rd = r; clr_err = c; din = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    f_en = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_clr_err = 1'b0; f_din = 32'h0;
    #12;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b want 1010", {empty, full, almost_empty, almost_full}); end
    checks++; if (dout !== 32'h0 || dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout got %h/%b want 0/0", dout, dout_valid); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
    checks++; if (f_dout_valid !== 1'b0 || f_empty !== 1'b1) begin errors++; $display("FAIL reset_fwft got v=%b e=%b want 0/1", f_dout_valid, f_empty); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'(i + 2));
      step();
      checks++;
      if (count !== 4'(i + 1) || almost_empty !== ((i + 1) <= 1) || almost_full !== ((i + 1) >= 6) || full !== (i == 7)) begin
        errors++;
        $display("FAIL fill_%0d got cnt=%0d ae=%b af=%b f=%b want cnt=%0d", i, count, almost_empty, almost_full, full, i + 1);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD);
    step();
    checks++; if (overflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL fill_overflow got ovf=%b cnt=%0d want 1/8", overflow, count); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      checks++;
      if (dout !== 32'(i + 2) || dout_valid !== 1'b1 || count !== 4'(7 - i) || empty !== (i == 7)) begin
        errors++;
        $display("FAIL drain_%0d got d=%h v=%b cnt=%0d e=%b want d=%h cnt=%0d", i, dout, dout_valid, count, empty, i + 2, 7 - i);
      end
    end
    step();
    checks++; if (underflow !== 1'b1 || dout !== 32'd9 || dout_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL drain_underflow got u=%b d=%h v=%b cnt=%0d want 1/9/0/0", underflow, dout, dout_valid, count); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_concurrent();
    logic [31:0] exp_q [$];
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL conc_clear got %b want 00", {overflow, underflow}); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'(i + 2));
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h55);
    step();
    checks++; if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || dout !== 32'd2) begin errors++; $display("FAIL conc_full got cnt=%0d f=%b ovf=%b d=%h want 8/1/0/2", count, full, overflow, dout); end
    for (int i = 3; i <= 9; i++) exp_q.push_back(32'(i));
    exp_q.push_back(32'h55);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      checks++; if (dout !== exp_q[i] || dout_valid !== 1'b1) begin errors++; $display("FAIL conc_read_%0d got %h/%b want %h/1", i, dout, dout_valid, exp_q[i]); end
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h77);
    step();
    checks++; if (count !== 4'd1 || underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== 32'h55) begin errors++; $display("FAIL conc_empty got cnt=%0d u=%b v=%b d=%h want 1/1/0/55", count, underflow, dout_valid, dout); end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    checks++; if (dout !== 32'h77 || count !== 4'd0) begin errors++; $display("FAIL conc_read77 got d=%h cnt=%0d want 77/0", dout, count); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_enable_clear();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
      step();
    end
    checks++; if (overflow !== 1'b1 || underflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL en_setup got o=%b u=%b cnt=%0d want 1/1/8", overflow, underflow, count); end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF);
      step();
      checks++;
      if (count !== 4'd8 || full !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b1 || dout !== 32'h77 || dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_hold_%0d got cnt=%0d o=%b u=%b d=%h v=%b want 8/1/1/77/0", i, count, overflow, underflow, dout, dout_valid);
      end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step();
    checks++; if ({overflow, underflow} !== 2'b00 || count !== 4'd8) begin errors++; $display("FAIL en_clear got %b cnt=%0d want 00/8", {overflow, underflow}, count); end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hBAD);
    step();
    checks++; if (overflow !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL set_wins got o=%b cnt=%0d want 1/8", overflow, count); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      step();
      checks++; if (dout !== 32'h100 + 32'(i)) begin errors++; $display("FAIL ar_pre_read_%0d got %h want %h", i, dout, 32'h100 + 32'(i)); end
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (count !== 4'd5 || overflow !== 1'b1) begin errors++; $display("FAIL ar_setup got cnt=%0d o=%b want 5/1", count, overflow); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_immediate got e=%b cnt=%0d f=%b o=%b u=%b v=%b want 1/0/0/0/0/0", empty, count, full, overflow, underflow, dout_valid);
    end
    #2;
    rst = 1'b1;
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hABC);
    step();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    checks++; if (dout !== 32'hABC || dout_valid !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL ar_after got d=%h v=%b cnt=%0d want abc/1/0", dout, dout_valid, count); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_fwft();
    checks++; if (f_dout_valid !== 1'b0) begin errors++; $display("FAIL fwft_idle got v=%b want 0", f_dout_valid); end
    f_en = 1'b1; f_wr = 1'b1; f_rd = 1'b0; f_din = 32'hA5;
    step();
    f_wr = 1'b0;
    checks++; if (f_dout !== 32'hA5 || f_dout_valid !== 1'b1) begin errors++; $display("FAIL fwft_first got %h/%b want a5/1", f_dout, f_dout_valid); end
    f_wr = 1'b1; f_din = 32'hB6;
    step();
    f_wr = 1'b0;
    checks++; if (f_dout !== 32'hA5 || f_count !== 4'd2) begin errors++; $display("FAIL fwft_hold got d=%h cnt=%0d want a5/2", f_dout, f_count); end
    f_rd = 1'b1;
    step();
    checks++; if (f_dout !== 32'hB6 || f_dout_valid !== 1'b1) begin errors++; $display("FAIL fwft_pop got %h/%b want b6/1", f_dout, f_dout_valid); end
    step();
    f_rd = 1'b0;
    checks++; if (f_empty !== 1'b1 || f_dout_valid !== 1'b0) begin errors++; $display("FAIL fwft_empty got e=%b v=%b want 1/0", f_empty, f_dout_valid); end
    f_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fwft();
    test_fill();
    test_drain();
    test_concurrent();
    test_enable_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO, the successor to the team's fixed synchronous FIFO. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It buffers data between producer and consumer stages in the same clock domain.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; must be a power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
ADDR_W, $clog2(DEPTH), derived pointer width; do not override

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; when 0, wr/rd/clr_err are ignored and all state holds
wr  in  1  write request
rd  in  1  read request (FWFT=1: pop/acknowledge of the head word)
din  in  DATA_W  write data
clr_err  in  1  synchronous clear of overflow/underflow (gated by en)
dout  out  DATA_W  read data
dout_valid  out  1  dout holds valid read data (see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not freed
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0. Memory is not reset; contents are discarded. The reset takes effect immediately, not at the next edge.
- rd_acc = en & rd & !empty.
- wr_acc = en & wr & (!full | rd_acc): a write while full is accepted if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH (natural ADDR_W wrap).
- On rd_acc: rd_ptr increments modulo DEPTH.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. All flags are registered or derived from the registered count; they update on the same edge as count.
- Simultaneous rd and wr when empty: write accepted, read rejected, underflow set, count becomes 1.
- Simultaneous rd and wr when full: both accepted, count stays DEPTH, FIFO order preserved.
- overflow: set on the edge where en & wr & full & !rd_acc. underflow: set on the edge where en & rd & empty. Both hold until clr_err=1 with en=1, or reset. If a set and clr_err occur in the same cycle, set wins.
- Rejected operations never modify memory, pointers or count.
- FWFT=0:
  - dout <= mem[rd_ptr] on the rd_acc edge (1-cycle read latency).
  - dout_valid is a 1-cycle pulse following each rd_acc.
  - dout holds its last value otherwise.
- FWFT=1:
  - dout = mem[rd_ptr] and dout_valid = !empty, continuously.
  - A word written into an empty FIFO appears on dout in the cycle after the write edge.
  - rd_acc advances dout to the next word.
  - When empty, dout value is don't-care and dout_valid=0.
- en=0: outputs and all state hold; no error flags are set.

Test Plan:
(Default parameters unless noted: DATA_W=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1, FWFT=0.)
- Fill: after reset, write 2..9 on 8 consecutive edges -> almost_empty drops when count=2, almost_full rises when count=6, full=1 and count=8 after the 8th; a 9th write of 0xDEAD -> overflow=1, count stays 8, 0xDEAD never read back.
- Drain: from full, assert rd for 8 cycles -> dout=2..9 each one cycle after its rd, dout_valid pulses; empty=1 after the 8th; an extra rd -> underflow=1, dout holds 9, dout_valid=0.
- Concurrent: when full, rd+wr with din=0x55 -> count stays 8, next 8 reads give 3..9 then 0x55; when empty, rd+wr with 0x77 -> count=1, underflow=1, next read gives 0x77.
- Enable/clear: en=0 with wr=rd=clr_err=1 for 5 cycles -> count, flags and dout unchanged; then en=1, clr_err=1 -> overflow=underflow=0.
- FWFT=1 instance: write 0xA5 into empty -> next cycle dout=0xA5, dout_valid=1 with no rd; write 0xB6, then rd -> dout=0xB6; second rd -> empty=1, dout_valid=0.
- Async reset mid-stream: with count=5, pull rst low between edges -> empty=1, count=0, full=0, flags=0 immediately; after release, a write then read returns the new data only.
